pool_stream_reader: RTL
=======================

# pool_stream_reader

Read-side companion of the binary max-pooling accumulator. It requests the pooled WL-bit feature vector from the pooling block with a one-cycle read strobe, captures it, and streams it out one bit per transfer, LSB first, with its bit address on a valid/ready handshake to the next network layer. It also reports the number of set bits once the frame is complete.

## Interface
- WL, 112: pooled vector width in bits.
- AW, 7: bit-address width; must satisfy 2^AW ≥ WL.
- iCLK  in  1  clock; all logic on the rising edge.
- iRSTn  in  1  reset; synchronous, active-low.
- iStart  in  1  frame request; sampled only in IDLE.
- oReadEN  out  1  read strobe to the pooling block; high for exactly one cycle per frame.
- iDATA  in  WL  pooled vector; valid during the cycle oReadEN is high.
- oValid  out  1  oBIT/oADDR/oLast valid.
- iReady  in  1  downstream accepts; transfer = oValid & iReady.
- oBIT  out  1  current pooled bit.
- oADDR  out  AW  index of oBIT, 0..WL-1.
- oLast  out  1  high with oValid when oADDR = WL-1.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse in the cycle after the last transfer.
- oOnes  out  AW+1  count of ones transferred in the last completed frame; held until the next frame is captured.

## Operation
- States: IDLE, REQ, SEND, DONE.
- IDLE: all strobes low. iStart=1 moves to REQ.
- REQ: oReadEN=1 for one cycle. At the closing edge, capture iDATA into the shift register, clear the address counter and the ones counter, and move to SEND.
- SEND: oValid=1, oBIT=shreg[0], oADDR=counter.
  - On a transfer: shift right by 1, counter+1, ones+oBIT.
  - If oLast is also set on that transfer, move to DONE instead.
  - Without a transfer, all outputs hold.
- DONE: oDone=1 and oOnes updated (includes the last bit). Return to IDLE unconditionally.
- iStart outside IDLE is ignored; it is not queued.
- iDATA is sampled only at the end of REQ; changes at any other time have no effect.
- oBIT/oADDR/oLast are 0 whenever oValid=0.
- Counter never exceeds WL-1; no wrap within a frame.
- oOnes max is WL and fits in AW+1 bits.
- Reset values: state=IDLE; oReadEN, oValid, oBIT, oADDR, oLast, oBusy, oDone all 0; oOnes=0; shift register 0.
- iRSTn low in any state, including mid-SEND, forces the reset values at the next edge. The partial frame is discarded and no oDone is produced.

## Timing
- Cycle numbers count from the edge that samples iStart=1 in IDLE (cycle 0).
- Cycle 1: REQ, oReadEN=1.
- Cycle 2: SEND, first bit on oValid.
- With iReady held high, bit k transfers in cycle 2+k and the last bit in cycle WL+1.
- Cycle WL+2: oDone.
- Cycle WL+3: IDLE; the earliest next iStart is sampled here.
- Each cycle of iReady=0 in SEND adds exactly one cycle of latency.
- oValid never drops before its transfer completes.
- oReadEN and iStart: no combinational path. oValid does not depend combinationally on iReady.

## Structure
- Shared package pool_pkg: WL, AW, and the state enum (IDLE/REQ/SEND/DONE). The pooling block uses the same WL/AW.
- Single module. Shift register, address counter and ones counter are inline; no sub-module is warranted.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles; iStart pulse with iReady=1 gives oReadEN exactly in cycle 1.
- iDATA=WL'h1 captured, iReady=1: oBIT=1 only at oADDR=0; oLast at addr 111; oDone in cycle 114; oOnes=1.
- All-ones vector, iReady toggling 1-0 each cycle: 112 transfers; addresses 0..111 contiguous, no duplicates; outputs stable while stalled; oOnes=112.
- iStart asserted continuously and iDATA changed every cycle after REQ: only the REQ-cycle value is streamed; a second oReadEN appears only after IDLE is re-entered.
- iRSTn low for 1 cycle at oADDR=50: next cycle all outputs 0, state IDLE, no oDone; a new frame starts cleanly from addr 0.
- Vector 112'hA5 repeated pattern (alternating 10100101 bytes, 56 ones): the streamed bits match the input LSB-first; oOnes=56 held until the next REQ capture.

Source files
------------

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared widths and read-side state encoding for the binary max-pooling block
package pool_pkg;

    localparam int WL = 112;
    localparam int AW = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } poolState_e;

endpackage

// File: rtl/pool_stream_reader_if.sv
// rtl/pool_stream_reader_if.sv - bit-serial pooled-feature stream with its bit address
interface pool_stream_reader_if;
    import pool_pkg::*;

    logic          oValid;
    logic          iReady;
    logic          oBIT;
    logic [AW-1:0] oADDR;
    logic          oLast;

    modport master (
        output oValid,
        output oBIT,
        output oADDR,
        output oLast,
        input  iReady
    );

    modport slave (
        input  oValid,
        input  oBIT,
        input  oADDR,
        input  oLast,
        output iReady
    );

endinterface

// File: rtl/pool_stream_reader.sv
// rtl/pool_stream_reader.sv - fetches one pooled vector and streams it LSB first with a popcount
module pool_stream_reader
    import pool_pkg::*;
(
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iStart,
    output logic                 oReadEN,
    input  logic [WL-1:0]        iDATA,
    pool_stream_reader_if.master strm,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [AW:0]          oOnes
);

    poolState_e    state;
    poolState_e    stateNext;

    logic [WL-1:0] shreg;
    logic [AW-1:0] addrCnt;
    logic [AW:0]   onesCnt;
    logic [AW:0]   onesReg;

    logic          sendValid;
    logic          xfer;
    logic          lastBit;
    logic [AW:0]   onesNext;

    assign lastBit  = (addrCnt == AW'(WL - 1));
    assign xfer     = sendValid & strm.iReady;
    assign onesNext = onesCnt + {{AW{1'b0}}, shreg[0]};

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        oReadEN   = 1'b0;
        sendValid = 1'b0;
        oBusy     = 1'b1;
        oDone     = 1'b0;
        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iStart) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                oReadEN   = 1'b1;
                stateNext = SEND;
            end
            SEND: begin
                sendValid = 1'b1;
                if (xfer && lastBit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Stream fields are forced to zero outside SEND so downstream never sees stale bits.
    assign strm.oValid = sendValid;
    assign strm.oBIT   = sendValid & shreg[0];
    assign strm.oADDR  = sendValid ? addrCnt : '0;
    assign strm.oLast  = sendValid & lastBit;
    assign oOnes       = onesReg;

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            shreg   <= '0;
            addrCnt <= '0;
            onesCnt <= '0;
            onesReg <= '0;
        end else begin
            case (state)
                REQ: begin
                    shreg   <= iDATA;
                    addrCnt <= '0;
                    onesCnt <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        shreg   <= shreg >> 1;
                        onesCnt <= onesNext;
                        // Address saturates at the last bit; the frame ends there.
                        if (lastBit) begin
                            onesReg <= onesNext;
                        end else begin
                            addrCnt <= addrCnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
